uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   Controller and byte buffer for the UART_RX receiver.
//   Owns UART_RX configuration (prescale, PAR_EN, PAR_TYPE) and its reset.
//   Applies new configuration only between frames, so no frame is ever corrupted.
//   Buffers received bytes in a small FIFO with a valid/ready output, plus an overflow flag and a byte counter.
// PARAMETERS
//   FIFO_DEPTH    4   byte FIFO entries (power of 2, >=2)
//   PRESCALE_RST  16  prescale applied after reset
//   HOLD_CYC      2   clk cycles rx_rst_n is held low on reset/reconfig
// PORTS
//   clk           in   1   single clock; all logic on posedge
//   rst           in   1   synchronous, active-high reset
//   cfg_valid     in   1   config request
//   cfg_ready     out  1   config accepted when cfg_valid & cfg_ready
//   cfg_prescale  in   5   requested prescale; legal values 4, 8, 16
//   cfg_par_en    in   1   requested parity enable
//   cfg_par_type  in   1   requested parity type (0 even, 1 odd)
//   cfg_err       out  1   1-cycle pulse: illegal prescale, request dropped
//   rx_line       in   1   copy of RX_IN, used for frame tracking
//   rx_rst_n      out  1   drives UART_RX rst; 0 holds the receiver in reset
//   rx_prescale   out  5   to UART_RX prescale
//   rx_par_en     out  1   to UART_RX PAR_EN
//   rx_par_type   out  1   to UART_RX PAR_TYPE
//   rx_data_valid in   1   from UART_RX data_valid
//   rx_p_data     in   8   from UART_RX P_Data
//   out_valid     out  1   FIFO non-empty
//   out_ready     in   1   consumer pop
//   out_data      out  8   FIFO head (fall-through)
//   overflow      out  1   sticky; set when a byte is dropped
//   byte_count    out  16  bytes accepted into FIFO, wraps at 0xFFFF->0
//   busy          out  1   1 whenever state != RUN
// BEHAVIOUR
//   Reset values:
//     rx_rst_n=0, rx_prescale=PRESCALE_RST, rx_par_en=0, rx_par_type=0.
//     cfg_ready=0, cfg_err=0, out_valid=0, overflow=0, byte_count=0, busy=1.
//     FIFO emptied.
//   FSM states:
//     HOLD -> RUN after HOLD_CYC cycles with rx_rst_n=0.
//     RUN: cfg_ready=1, rx_rst_n=1.
//       Legal request accepted: latch into pending regs, -> WAIT_IDLE.
//       Illegal request: cfg_err pulses, stay in RUN.
//     WAIT_IDLE: cfg_ready=0; wait until frame_active=0 and rx_line=1, -> APPLY.
//     APPLY: rx_* outputs take the pending values on entry; rx_rst_n=0 for HOLD_CYC cycles, -> RUN.
//       Minimum request-to-RUN latency when idle: 1 + 1 + HOLD_CYC cycles.
//   Frame tracker:
//     Falling edge of rx_line (registered 1->0) while not active starts a frame.
//     A frame lasts (10 + rx_par_en) * rx_prescale cycles; 9-bit down-counter.
//     Edges inside an active frame are ignored.
//     Tracker is cleared in HOLD and APPLY.
//   Simultaneous events:
//     A falling edge in the same cycle WAIT_IDLE would exit: the frame wins; stay in WAIT_IDLE.
//     rx_data_valid while rx_rst_n=0: ignored.
//   FIFO:
//     Push on rx_data_valid & rx_rst_n; pop on out_valid & out_ready.
//     Full + push with no pop: byte dropped, overflow<=1, byte_count unchanged.
//     Full + push + pop in the same cycle: both succeed, no overflow.
//     Empty + pop: no effect.
//     FIFO contents are preserved across reconfiguration.
//   byte_count increments on every accepted push.
//   rst asserted mid-frame or mid-reconfig: everything returns to reset values next cycle; the pending request is lost.
// STRUCTURE
//   uart_pkg:
//     FSM state encodings (HOLD, RUN, WAIT_IDLE, APPLY).
//     Legal prescale constants.
//     FRAME_BITS_NOPAR=10, FRAME_BITS_PAR=11.
//   Sub-module uart_rx_fifo: synchronous FIFO with fall-through head; parameter FIFO_DEPTH, 8-bit data.
//   FSM, frame tracker and counters live in uart_rx_ctrl.
//   UART_RX is instantiated as a sibling at the top level.
// TESTING
//   Bench instantiates uart_rx_ctrl + UART_RX.
//   1. Reset release: rx_rst_n=0 for 2 cycles then 1; rx_prescale=16; busy falls at cycle 3.
//   2. Frame 0_11000101_1 at prescale 16, no parity:
//      out_valid=1, out_data=8'hA3, byte_count=1.
//   3. Request prescale 8 + even parity, issued mid-frame:
//      Config is not applied until the frame ends; byte 8'hA3 is still received.
//      Then rx_prescale=8 and rx_par_en=1.
//      Next frame 0_11000101_0_1 yields 8'hA3.
//   4. cfg_prescale=5: cfg_err pulses 1 cycle; rx_* outputs unchanged; stay in RUN.
//   5. out_ready=0, send 5 frames:
//      First 4 bytes held, overflow=1, byte_count=4.
//      Pop with a push in the same cycle at full: no further overflow-driven drop.
//   6. Assert rst during WAIT_IDLE:
//      All outputs at reset values next cycle; FIFO empty; the request is not applied.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART receive controller slice.
//   - FSM state encodings for uart_rx_ctrl (HOLD, RUN, WAIT_IDLE, APPLY)
//   - Legal receiver prescale values
//   - Frame bit counts with and without parity
//   - Receiver configuration record and small helper functions
package uart_pkg;

    // Controller FSM encodings, kept as plain constants for legacy tooling.
    localparam logic [1:0] ST_HOLD      = 2'd0;
    localparam logic [1:0] ST_RUN       = 2'd1;
    localparam logic [1:0] ST_WAIT_IDLE = 2'd2;
    localparam logic [1:0] ST_APPLY     = 2'd3;

    // Oversampling factors the receiver supports.
    localparam logic [4:0] PRESCALE_4  = 5'd4;
    localparam logic [4:0] PRESCALE_8  = 5'd8;
    localparam logic [4:0] PRESCALE_16 = 5'd16;

    // start + 8 data + stop, optionally + parity
    localparam int unsigned FRAME_BITS_NOPAR = 10;
    localparam int unsigned FRAME_BITS_PAR   = 11;

    // Configuration as seen by the receiver.
    typedef struct packed {
        logic [4:0] prescale;
        logic       par_en;
        logic       par_type;
    } rx_cfg_t;

    function automatic logic prescale_legal(input logic [4:0] prescale);
        return (prescale == PRESCALE_4) || (prescale == PRESCALE_8) ||
               (prescale == PRESCALE_16);
    endfunction

    // Frame length in clk cycles; worst case 11 * 16 = 176 fits in 9 bits.
    function automatic logic [8:0] frame_len(input logic par_en, input logic [4:0] prescale);
        logic [8:0] bits;
        bits = par_en ? 9'(FRAME_BITS_PAR) : 9'(FRAME_BITS_NOPAR);
        return bits * 9'(prescale);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Synchronous byte FIFO with a fall-through head: head_data shows the
//   oldest entry whenever empty is low, with no read latency.
//   A push while full is accepted only if a pop happens in the same cycle.
// Ports
//   clk        in   clock, all state on posedge
//   rst        in   synchronous active-high reset, empties the FIFO
//   push       in   write request
//   push_data  in   byte to write
//   pop        in   read request, ignored when empty
//   head_data  out  oldest byte (valid when empty is low)
//   empty      out  no entries
//   full       out  FIFO_DEPTH entries
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       empty,
    output logic       full
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // When full, the slot being freed by the pop is the one written.
    assign do_push = push & (~full | do_pop);

    assign head_data = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Controller and byte buffer for a UART receiver.
//   Owns the receiver configuration and reset, defers reconfiguration until
//   the line is between frames, and buffers received bytes in a FIFO with a
//   valid/ready output, a sticky overflow flag and an accepted-byte counter.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   cfg_valid/cfg_ready          configuration handshake
//   cfg_prescale/par_en/par_type requested configuration
//   cfg_err                      1-cycle pulse, illegal prescale dropped
//   rx_line                      copy of the serial line, for frame tracking
//   rx_rst_n                     receiver reset, low holds it in reset
//   rx_prescale/par_en/par_type  applied configuration to the receiver
//   rx_data_valid/rx_p_data      received byte from the receiver
//   out_valid/out_ready/out_data byte output stream (FIFO head)
//   overflow                     sticky, a byte was dropped
//   byte_count                   bytes accepted into the FIFO, wrapping
//   busy                         high whenever not in RUN
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PRESCALE_RST = 16,
    parameter int unsigned HOLD_CYC     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [4:0]  cfg_prescale,
    input  logic        cfg_par_en,
    input  logic        cfg_par_type,
    output logic        cfg_err,
    input  logic        rx_line,
    output logic        rx_rst_n,
    output logic [4:0]  rx_prescale,
    output logic        rx_par_en,
    output logic        rx_par_type,
    input  logic        rx_data_valid,
    input  logic [7:0]  rx_p_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        overflow,
    output logic [15:0] byte_count,
    output logic        busy
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam rx_cfg_t CFG_RST = '{prescale: 5'(PRESCALE_RST), par_en: 1'b0, par_type: 1'b0};

    logic [1:0]        state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              hold_done;
    rx_cfg_t           cfg_q, cfg_d;
    rx_cfg_t           pend_q, pend_d;
    rx_cfg_t           req;
    logic              cfg_err_q, cfg_err_d;

    logic              line_q;
    logic [8:0]        frame_cnt_q, frame_cnt_d;
    logic              tracker_en, line_fall, frame_active, frame_start;

    logic              push, pop, fifo_empty, fifo_full, push_accept;
    logic              overflow_q, overflow_d;
    logic [15:0]       byte_count_q, byte_count_d;

    // ---------------------------------------------------------------
    // Frame tracker
    // ---------------------------------------------------------------
    // Only meaningful while the receiver is out of reset.
    assign tracker_en   = (state_q == ST_RUN) || (state_q == ST_WAIT_IDLE);
    assign line_fall    = line_q & ~rx_line;
    assign frame_active = (frame_cnt_q != 9'd0);
    assign frame_start  = tracker_en & line_fall & ~frame_active;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!tracker_en) begin
            frame_cnt_d = 9'd0;
        end else if (frame_start) begin
            // Loaded with length-1 so the counter is back to zero in the
            // last frame cycle; a start bit right after the stop bit is seen.
            frame_cnt_d = frame_len(cfg_q.par_en, cfg_q.prescale) - 9'd1;
        end else if (frame_active) begin
            frame_cnt_d = frame_cnt_q - 9'd1;
        end
    end

    // ---------------------------------------------------------------
    // Configuration FSM
    // ---------------------------------------------------------------
    assign req       = '{prescale: cfg_prescale, par_en: cfg_par_en, par_type: cfg_par_type};
    assign hold_done = (hold_cnt_q == HOLD_W'(HOLD_CYC - 1));

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cfg_d      = cfg_q;
        pend_d     = pend_q;
        cfg_err_d  = 1'b0;
        case (state_q)
            ST_HOLD, ST_APPLY: begin
                if (hold_done) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (cfg_valid) begin
                    if (prescale_legal(cfg_prescale)) begin
                        pend_d  = req;
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A start bit arriving this cycle keeps us waiting.
                if (!frame_active && rx_line && !frame_start) begin
                    state_d    = ST_APPLY;
                    cfg_d      = pend_q;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign cfg_ready   = (state_q == ST_RUN);
    assign rx_rst_n    = (state_q == ST_RUN) || (state_q == ST_WAIT_IDLE);
    assign busy        = (state_q != ST_RUN);
    assign cfg_err     = cfg_err_q;
    assign rx_prescale = cfg_q.prescale;
    assign rx_par_en   = cfg_q.par_en;
    assign rx_par_type = cfg_q.par_type;

    // ---------------------------------------------------------------
    // Byte buffer, overflow and counter
    // ---------------------------------------------------------------
    // Bytes reported while the receiver is held in reset are discarded.
    assign push        = rx_data_valid & rx_rst_n;
    assign pop         = out_valid & out_ready;
    assign push_accept = push & (~fifo_full | pop);

    always_comb begin
        overflow_d   = overflow_q | (push & fifo_full & ~pop);
        byte_count_d = byte_count_q;
        if (push_accept) begin
            byte_count_d = byte_count_q + 16'd1;
        end
    end

    uart_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rx_p_data),
        .pop       (pop),
        .head_data (out_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid  = ~fifo_empty;
    assign overflow   = overflow_q;
    assign byte_count = byte_count_q;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= '0;
            cfg_q        <= CFG_RST;
            pend_q       <= CFG_RST;
            cfg_err_q    <= 1'b0;
            line_q       <= 1'b1;
            frame_cnt_q  <= 9'd0;
            overflow_q   <= 1'b0;
            byte_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            cfg_q        <= cfg_d;
            pend_q       <= pend_d;
            cfg_err_q    <= cfg_err_d;
            line_q       <= rx_line;
            frame_cnt_q  <= frame_cnt_d;
            overflow_q   <= overflow_d;
            byte_count_q <= byte_count_d;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. The receiver is emulated: the bench
// serialises frames onto rx_line and reports the byte mid stop bit.
module tb_uart_rx_ctrl;

    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_valid = 1'b0;
    logic [4:0]  cfg_prescale = 5'd16;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_type = 1'b0;
    logic        rx_line = 1'b1;
    logic        out_ready = 1'b0;
    logic        fr_valid = 1'b0;
    logic [7:0]  fr_data = 8'h00;
    logic        dir_valid = 1'b0;
    logic [7:0]  dir_data = 8'h00;
    logic        rx_data_valid;
    logic [7:0]  rx_p_data;

    logic        cfg_ready, cfg_err, rx_rst_n, rx_par_en, rx_par_type;
    logic        out_valid, overflow, busy;
    logic [4:0]  rx_prescale;
    logic [7:0]  out_data;
    logic [15:0] byte_count;

    assign rx_data_valid = fr_valid | dir_valid;
    assign rx_p_data     = fr_valid ? fr_data : dir_data;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .PRESCALE_RST (16),
        .HOLD_CYC     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_prescale  (cfg_prescale),
        .cfg_par_en    (cfg_par_en),
        .cfg_par_type  (cfg_par_type),
        .cfg_err       (cfg_err),
        .rx_line       (rx_line),
        .rx_rst_n      (rx_rst_n),
        .rx_prescale   (rx_prescale),
        .rx_par_en     (rx_par_en),
        .rx_par_type   (rx_par_type),
        .rx_data_valid (rx_data_valid),
        .rx_p_data     (rx_p_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .overflow      (overflow),
        .byte_count    (byte_count),
        .busy          (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------------------------------------------------------
    // Serial line emulation: one queue entry per clk cycle
    // ---------------------------------------------------------------
    logic       line_seq[$];
    logic       vld_seq[$];
    logic [7:0] dat_seq[$];

    always @(posedge clk) begin
        #1;
        if (line_seq.size() > 0) begin
            rx_line  = line_seq.pop_front();
            fr_valid = vld_seq.pop_front();
            fr_data  = dat_seq.pop_front();
        end else begin
            rx_line  = 1'b1;
            fr_valid = 1'b0;
        end
    end

    task automatic queue_frame(input logic [7:0] b, input logic pe, input logic pt,
                               input int ps, input int gap);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (pe) bits.push_back((^b) ^ pt);
        bits.push_back(1'b1);
        for (int k = 0; k < bits.size(); k++) begin
            for (int c = 0; c < ps; c++) begin
                line_seq.push_back(bits[k]);
                vld_seq.push_back((k == bits.size() - 1) && (c == ps / 2));
                dat_seq.push_back(b);
            end
        end
        for (int g = 0; g < gap; g++) begin
            line_seq.push_back(1'b1);
            vld_seq.push_back(1'b0);
            dat_seq.push_back(8'h00);
        end
    endtask

    task automatic drain_line();
        int guard;
        guard = 0;
        while (line_seq.size() > 0 && guard < 5000) begin
            step();
            guard++;
        end
    endtask

    task automatic wait_run(input string name, input int limit);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < limit) begin
            step();
            k++;
        end
        check(name, busy, 1'b0);
    endtask

    // ---------------------------------------------------------------
    // Byte stream reference: a queue of accepted bytes
    // ---------------------------------------------------------------
    logic [7:0] mq[$];
    int         m_count = 0;
    bit         m_ovf = 0;
    bit         model_ignore = 0;
    bit         sb_pop, sb_push;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_count = 0;
            m_ovf   = 0;
        end else begin
            sb_pop  = (mq.size() > 0) && out_ready;
            sb_push = rx_data_valid && !model_ignore;
            if (sb_push && mq.size() == FIFO_DEPTH && !sb_pop) begin
                m_ovf = 1;
            end else begin
                if (sb_pop) void'(mq.pop_front());
                if (sb_push) begin
                    mq.push_back(rx_p_data);
                    m_count = (m_count + 1) & 16'hFFFF;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("sb_out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) check("sb_out_data", out_data, mq[0]);
        check("sb_byte_count", byte_count, m_count);
        check("sb_overflow", overflow, m_ovf);
    end

    task automatic check_reset(input string pfx);
        check({pfx, "_rx_rst_n"}, rx_rst_n, 1'b0);
        check({pfx, "_rx_prescale"}, rx_prescale, 5'd16);
        check({pfx, "_rx_par_en"}, rx_par_en, 1'b0);
        check({pfx, "_rx_par_type"}, rx_par_type, 1'b0);
        check({pfx, "_cfg_ready"}, cfg_ready, 1'b0);
        check({pfx, "_cfg_err"}, cfg_err, 1'b0);
        check({pfx, "_out_valid"}, out_valid, 1'b0);
        check({pfx, "_overflow"}, overflow, 1'b0);
        check({pfx, "_byte_count"}, byte_count, 16'd0);
        check({pfx, "_busy"}, busy, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        line_seq.delete();
        vld_seq.delete();
        dat_seq.delete();
        step();
        rst = 1'b0;
        step(2);
    endtask

    task automatic request(input logic [4:0] ps, input logic pe, input logic pt);
        cfg_valid    = 1'b1;
        cfg_prescale = ps;
        cfg_par_en   = pe;
        cfg_par_type = pt;
        step();
        cfg_valid = 1'b0;
    endtask

    typedef struct packed {
        logic [4:0] ps;
        logic       pe;
        logic       pt;
        logic       err;
        logic [4:0] eps;
        logic       epe;
        logic       ept;
    } cfg_vec_t;

    cfg_vec_t   cfg_tbl[8];
    logic [7:0] sent[5];
    logic [7:0] exp3[3];
    logic [4:0] legal[3];

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         bad;
        int         bc0;
        logic [4:0] ps;
        logic       pe, pt;
        logic [7:0] b;

        cfg_tbl[0] = '{5'd5,  1'b0, 1'b0, 1'b1, 5'd8,  1'b1, 1'b0};
        cfg_tbl[1] = '{5'd4,  1'b1, 1'b1, 1'b0, 5'd4,  1'b1, 1'b1};
        cfg_tbl[2] = '{5'd0,  1'b1, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1};
        cfg_tbl[3] = '{5'd16, 1'b0, 1'b1, 1'b0, 5'd16, 1'b0, 1'b1};
        cfg_tbl[4] = '{5'd31, 1'b1, 1'b1, 1'b1, 5'd16, 1'b0, 1'b1};
        cfg_tbl[5] = '{5'd8,  1'b0, 1'b0, 1'b0, 5'd8,  1'b0, 1'b0};
        cfg_tbl[6] = '{5'd12, 1'b0, 1'b0, 1'b1, 5'd8,  1'b0, 1'b0};
        cfg_tbl[7] = '{5'd16, 1'b0, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0};
        legal[0] = 5'd4;
        legal[1] = 5'd8;
        legal[2] = 5'd16;
        exp3[0] = 8'hA3;
        exp3[1] = 8'h5C;
        exp3[2] = 8'hA3;

        // 1. Reset and release: receiver held for two cycles.
        rst = 1'b1;
        step(3);
        check_reset("t1");
        rst = 1'b0;
        step();
        check("t1_hold_rx_rst_n", rx_rst_n, 1'b0);
        check("t1_hold_busy", busy, 1'b1);
        step();
        check("t1_run_rx_rst_n", rx_rst_n, 1'b1);
        check("t1_run_busy", busy, 1'b0);
        check("t1_run_cfg_ready", cfg_ready, 1'b1);

        // 2. One frame at prescale 16, no parity.
        queue_frame(8'hA3, 1'b0, 1'b0, 16, 2);
        drain_line();
        step(2);
        check("t2_out_valid", out_valid, 1'b1);
        check("t2_out_data", out_data, 8'hA3);
        check("t2_byte_count", byte_count, 16'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t2_popped", out_valid, 1'b0);

        // 3. Reconfigure mid-frame, a second frame follows back to back.
        queue_frame(8'hA3, 1'b0, 1'b0, 16, 0);
        queue_frame(8'h5C, 1'b0, 1'b0, 16, 1);
        step(40);
        check("t3_cfg_ready", cfg_ready, 1'b1);
        request(5'd8, 1'b1, 1'b0);
        check("t3_wait_busy", busy, 1'b1);
        check("t3_wait_cfg_ready", cfg_ready, 1'b0);
        bad = 0;
        while (line_seq.size() > 0) begin
            if (rx_prescale !== 5'd16 || rx_rst_n !== 1'b1) bad++;
            step();
        end
        check("t3_deferred_cycles_bad", bad, 0);
        step();
        check("t3_apply_rx_rst_n", rx_rst_n, 1'b0);
        check("t3_apply_prescale", rx_prescale, 5'd8);
        check("t3_apply_par_en", rx_par_en, 1'b1);
        step();
        check("t3_apply2_rx_rst_n", rx_rst_n, 1'b0);
        step();
        check("t3_run_rx_rst_n", rx_rst_n, 1'b1);
        check("t3_run_busy", busy, 1'b0);
        queue_frame(8'hA3, 1'b1, 1'b0, 8, 2);
        drain_line();
        step(2);
        check("t3_byte_count", byte_count, 16'd4);
        for (int i = 0; i < 3; i++) begin
            check("t3_pop_data", out_data, exp3[i]);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("t3_empty", out_valid, 1'b0);

        // 4. Table of configuration requests from an idle line.
        for (int i = 0; i < 8; i++) begin
            check("t4_cfg_ready", cfg_ready, 1'b1);
            request(cfg_tbl[i].ps, cfg_tbl[i].pe, cfg_tbl[i].pt);
            if (cfg_tbl[i].err) begin
                check("t4_err_pulse", cfg_err, 1'b1);
                check("t4_err_busy", busy, 1'b0);
                step();
                check("t4_err_clear", cfg_err, 1'b0);
            end else begin
                check("t4_no_err", cfg_err, 1'b0);
                check("t4_wait_rx_rst_n", rx_rst_n, 1'b1);
                check("t4_wait_busy", busy, 1'b1);
                step();
                check("t4_apply_rx_rst_n", rx_rst_n, 1'b0);
                step();
                check("t4_apply2_rx_rst_n", rx_rst_n, 1'b0);
                step();
                check("t4_run_rx_rst_n", rx_rst_n, 1'b1);
                check("t4_run_busy", busy, 1'b0);
            end
            check("t4_prescale", rx_prescale, cfg_tbl[i].eps);
            check("t4_par_en", rx_par_en, cfg_tbl[i].epe);
            check("t4_par_type", rx_par_type, cfg_tbl[i].ept);
        end

        // Byte reported while the receiver is held in reset is dropped.
        bc0 = m_count;
        request(5'd16, 1'b0, 1'b0);
        step();
        check("t4b_in_apply", rx_rst_n, 1'b0);
        dir_valid    = 1'b1;
        dir_data     = 8'h77;
        model_ignore = 1'b1;
        step();
        dir_valid    = 1'b0;
        model_ignore = 1'b0;
        check("t4b_count_held", byte_count, bc0);
        check("t4b_no_push", out_valid, 1'b0);
        wait_run("t4b_back_to_run", 10);

        // 5. Overflow with five frames and no consumer.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            sent[i] = 8'($urandom);
            queue_frame(sent[i], 1'b0, 1'b0, 16, 1);
        end
        drain_line();
        step(2);
        check("t5_overflow", overflow, 1'b1);
        check("t5_byte_count", byte_count, 16'd4);
        for (int i = 0; i < 4; i++) begin
            check("t5_pop_data", out_data, sent[i]);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        check("t5_empty", out_valid, 1'b0);

        // Full with simultaneous push and pop: no drop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            dir_valid = 1'b1;
            dir_data  = 8'h10 + 8'(i);
            step();
        end
        dir_valid = 1'b0;
        check("t5b_full_no_ovf", overflow, 1'b0);
        dir_valid = 1'b1;
        dir_data  = 8'h99;
        out_ready = 1'b1;
        step();
        dir_valid = 1'b0;
        out_ready = 1'b0;
        check("t5b_pushpop_no_ovf", overflow, 1'b0);
        check("t5b_pushpop_count", byte_count, 16'd5);
        check("t5b_pushpop_head", out_data, 8'h11);
        dir_valid = 1'b1;
        dir_data  = 8'hEE;
        step();
        dir_valid = 1'b0;
        check("t5b_drop_ovf", overflow, 1'b1);
        check("t5b_drop_count", byte_count, 16'd5);

        // Randomized configurations and frames.
        do_reset();
        for (int it = 0; it < 6; it++) begin
            ps = legal[$urandom_range(0, 2)];
            pe = 1'($urandom_range(0, 1));
            pt = 1'($urandom_range(0, 1));
            request(ps, pe, pt);
            wait_run("rnd_cfg_run", 20);
            check("rnd_prescale", rx_prescale, ps);
            check("rnd_par_en", rx_par_en, pe);
            check("rnd_par_type", rx_par_type, pt);
            out_ready = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            queue_frame(b, pe, pt, int'(ps), 3);
            drain_line();
            step(2);
        end

        // Randomized FIFO traffic, first filling then draining bias.
        for (int i = 0; i < 600; i++) begin
            dir_valid = ($urandom_range(0, 2) == 0);
            dir_data  = 8'($urandom);
            out_ready = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step();
        end
        dir_valid = 1'b0;
        out_ready = 1'b1;
        step(6);
        out_ready = 1'b0;
        check("rnd_drained", out_valid, 1'b0);

        // 6. Reset while waiting to reconfigure.
        dir_valid = 1'b1;
        dir_data  = 8'h3C;
        step();
        dir_valid = 1'b0;
        queue_frame(8'hA3, 1'b0, 1'b0, int'(rx_prescale), 1);
        step(30);
        request(5'd8, 1'b1, 1'b1);
        check("t6_wait_busy", busy, 1'b1);
        check("t6_wait_rx_rst_n", rx_rst_n, 1'b1);
        step(5);
        rst = 1'b1;
        line_seq.delete();
        vld_seq.delete();
        dat_seq.delete();
        step();
        check_reset("t6");
        rst = 1'b0;
        step(2);
        check("t6_run_busy", busy, 1'b0);
        step(10);
        check("t6_not_applied_ps", rx_prescale, 5'd16);
        check("t6_not_applied_pe", rx_par_en, 1'b0);
        check("t6_not_applied_pt", rx_par_type, 1'b0);
        check("t6_still_run", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
